// File: rtl/bist_pkg.sv
// Shared BIST definitions: controller state encoding and default MISR constants,
// also used by the upstream pattern generator.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_t;

    localparam int unsigned           BIST_RESP_W = 7;
    localparam int unsigned           BIST_MISR_W = 16;
    localparam logic [BIST_MISR_W-1:0] BIST_POLY   = 16'h1021;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: Galois-style shift with polynomial feedback,
// XORing in one zero-extended response word per enabled cycle.
module misr_core
    import bist_pkg::*;
#(
    parameter int unsigned           RESP_W = BIST_RESP_W,
    parameter int unsigned           MISR_W = BIST_MISR_W,
    parameter logic [MISR_W-1:0]     POLY   = BIST_POLY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [RESP_W-1:0] din,
    output logic [MISR_W-1:0] q
);

    logic [MISR_W-1:0] misr_next;

    always_comb begin
        misr_next = {q[MISR_W-2:0], 1'b0} ^ (q[MISR_W-1] ? POLY : '0) ^ MISR_W'(din);
    end

    // clr wins over en so a restart never folds in a stale response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= misr_next;
        end
    end

endmodule

// File: rtl/misr_bist_ctrl.sv
// BIST run controller: sequences IDLE/RUN/CHECK/DONE, counts accepted responses
// and compares the compacted signature against GOLDEN.
module misr_bist_ctrl
    import bist_pkg::*;
#(
    parameter int unsigned           RESP_W  = BIST_RESP_W,
    parameter int unsigned           MISR_W  = BIST_MISR_W,
    parameter logic [MISR_W-1:0]     POLY    = BIST_POLY,
    parameter int unsigned           PAT_CNT = 1024,
    parameter logic [MISR_W-1:0]     GOLDEN  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [RESP_W-1:0] resp,
    input  logic              resp_valid,
    output logic              pat_en,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature
);

    localparam logic [15:0] LAST_IDX = 16'(PAT_CNT - 1);

    bist_state_t state;
    logic [15:0] cnt;
    logic        pass_r;
    logic        go_run;
    logic        accept;

    // abort outranks both a (re)start and the final accept of a run
    always_comb begin
        go_run = start && !abort && (state == ST_IDLE || state == ST_DONE);
        accept = (state == ST_RUN) && resp_valid && !abort;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            pass_r <= 1'b0;
        end else if (abort) begin
            state  <= ST_IDLE;
            pass_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (go_run) begin
                        state  <= ST_RUN;
                        cnt    <= '0;
                        pass_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        cnt <= cnt + 16'd1;
                        if (cnt == LAST_IDX) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    pass_r <= (signature == GOLDEN);
                    state  <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    misr_core #(
        .RESP_W (RESP_W),
        .MISR_W (MISR_W),
        .POLY   (POLY)
    ) u_misr (
        .clk   (clk),
        .reset (reset),
        .clr   (go_run),
        .en    (accept),
        .din   (resp),
        .q     (signature)
    );

    always_comb begin
        pat_en = (state == ST_RUN);
        busy   = (state == ST_RUN) || (state == ST_CHECK);
        done   = (state == ST_DONE);
        pass   = pass_r;
    end

endmodule

// File: tb/tb_misr_bist_ctrl.sv
// Directed self-checking bench for misr_bist_ctrl; two instances cover PAT_CNT=4 and 11.
module tb_misr_bist_ctrl;

    logic        clk;
    logic        reset;
    logic        start4;
    logic        start11;
    logic        abort;
    logic [6:0]  resp;
    logic        resp_valid;

    logic        pat_en4, busy4, done4, pass4;
    logic [15:0] sig4;
    logic        pat_en11, busy11, done11, pass11;
    logic [15:0] sig11;

    int unsigned errors = 0;
    int unsigned checks = 0;

    misr_bist_ctrl #(
        .RESP_W  (7),
        .MISR_W  (16),
        .POLY    (16'h1021),
        .PAT_CNT (4),
        .GOLDEN  (16'h0000)
    ) dut4 (
        .clk        (clk),
        .reset      (reset),
        .start      (start4),
        .abort      (abort),
        .resp       (resp),
        .resp_valid (resp_valid),
        .pat_en     (pat_en4),
        .busy       (busy4),
        .done       (done4),
        .pass       (pass4),
        .signature  (sig4)
    );

    misr_bist_ctrl #(
        .RESP_W  (7),
        .MISR_W  (16),
        .POLY    (16'h1021),
        .PAT_CNT (11),
        .GOLDEN  (16'h0000)
    ) dut11 (
        .clk        (clk),
        .reset      (reset),
        .start      (start11),
        .abort      (abort),
        .resp       (resp),
        .resp_valid (resp_valid),
        .pat_en     (pat_en11),
        .busy       (busy11),
        .done       (done11),
        .pass       (pass11),
        .signature  (sig11)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic feed(input logic [6:0] r, input logic v);
        resp       = r;
        resp_valid = v;
        @(negedge clk);
    endtask

    task automatic pulse_start4();
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    // one start, then 1 followed by three zeros: expected signature 0x0008
    task automatic run_one_then_zeros(input string tag);
        pulse_start4();
        check({tag, "_sig_clr"}, 32'(sig4), 32'h0);
        feed(7'h01, 1'b1);
        feed(7'h00, 1'b1);
        feed(7'h00, 1'b1);
        feed(7'h00, 1'b1);
        feed(7'h00, 1'b0);
        check({tag, "_done"}, 32'(done4), 32'h1);
        check({tag, "_sig"},  32'(sig4),  32'h0008);
        check({tag, "_pass"}, 32'(pass4), 32'h0);
    endtask

    initial begin
        reset      = 1'b0;
        start4     = 1'b0;
        start11    = 1'b0;
        abort      = 1'b0;
        resp       = '0;
        resp_valid = 1'b0;
        #3;
        check("rst_sig",    32'(sig4),    32'h0);
        check("rst_busy",   32'(busy4),   32'h0);
        check("rst_done",   32'(done4),   32'h0);
        check("rst_pat_en", 32'(pat_en4), 32'h0);
        check("rst_pass",   32'(pass4),   32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // all-zero responses match GOLDEN=0; done two edges after the 4th accept
        pulse_start4();
        check("t1_pat_en", 32'(pat_en4), 32'h1);
        check("t1_busy",   32'(busy4),   32'h1);
        for (int i = 0; i < 4; i++) feed(7'h00, 1'b1);
        resp_valid = 1'b0;
        check("t1_check_busy", 32'(busy4),   32'h1);
        check("t1_check_done", 32'(done4),   32'h0);
        check("t1_check_pen",  32'(pat_en4), 32'h0);
        @(negedge clk);
        check("t1_done", 32'(done4), 32'h1);
        check("t1_pass", 32'(pass4), 32'h1);
        check("t1_sig",  32'(sig4),  32'h0);
        feed(7'h7f, 1'b1);
        feed(7'h7f, 1'b1);
        check("t1_hold_done", 32'(done4), 32'h1);
        check("t1_hold_pass", 32'(pass4), 32'h1);
        check("t1_hold_sig",  32'(sig4),  32'h0);

        // restart from DONE
        run_one_then_zeros("t2");

        // feedback path on the PAT_CNT=11 instance
        start11 = 1'b1;
        @(negedge clk);
        start11 = 1'b0;
        feed(7'h40, 1'b1);
        for (int i = 0; i < 10; i++) feed(7'h00, 1'b1);
        feed(7'h00, 1'b0);
        check("t3_done", 32'(done11), 32'h1);
        check("t3_sig",  32'(sig11),  32'h1021);
        check("t3_pass", 32'(pass11), 32'h0);
        check("t3_other_idle_sig", 32'(sig4), 32'h0008);

        // gapped valid; start mid-run must be ignored
        pulse_start4();
        for (int i = 0; i < 7; i++) begin
            check("t4_pat_en", 32'(pat_en4), 32'h1);
            start4 = (i == 3);
            feed(7'h01, (i % 2) == 0);
        end
        start4     = 1'b0;
        resp_valid = 1'b0;
        check("t4_in_check", 32'(busy4) << 1 | 32'(done4), 32'h2);
        @(negedge clk);
        check("t4_done", 32'(done4), 32'h1);
        check("t4_sig",  32'(sig4),  32'h000F);

        // abort after two accepts, same cycle as a valid response
        pulse_start4();
        feed(7'h01, 1'b1);
        feed(7'h01, 1'b1);
        abort = 1'b1;
        feed(7'h01, 1'b1);
        abort = 1'b0;
        check("t5_busy",   32'(busy4),   32'h0);
        check("t5_done",   32'(done4),   32'h0);
        check("t5_pass",   32'(pass4),   32'h0);
        check("t5_pat_en", 32'(pat_en4), 32'h0);
        check("t5_sig_kept", 32'(sig4),  32'h0003);
        feed(7'h01, 1'b1);
        feed(7'h01, 1'b1);
        check("t5_idle_no_accept", 32'(sig4), 32'h0003);
        feed(7'h00, 1'b0);
        run_one_then_zeros("t5r");

        // asynchronous reset between edges mid-run
        pulse_start4();
        feed(7'h01, 1'b1);
        feed(7'h00, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_sig",    32'(sig4),    32'h0);
        check("t6_busy",   32'(busy4),   32'h0);
        check("t6_pat_en", 32'(pat_en4), 32'h0);
        check("t6_done",   32'(done4),   32'h0);
        resp_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_one_then_zeros("t6r");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
